instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Initiator side of the instruction memory interface. Holds the fetch PC, drives a 10-bit word address into the combinational-read instruction memory, and captures the returned 32-bit word into a small prefetch FIFO. Delivers instructions with their PC to decode over a valid/ready handshake. Supports backpressure, a branch/jump redirect that flushes the queue, and a delivered-instruction counter.

Parameters:
ADDR_WIDTH, 10, word address width; matches the 1024-word memory
DATA_WIDTH, 32, instruction width
RESET_PC, 0, fetch PC loaded at reset
FIFO_DEPTH, 4, prefetch queue entries; power of two, at least 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_enable  input  1  when 0, no new fetches; queue still drains
imem_address  output  ADDR_WIDTH  word address to instruction memory; combinational copy of fetch_pc
imem_instruction  input  DATA_WIDTH  word returned by memory in the same cycle
redirect_valid  input  1  flush queue and restart fetch at redirect_pc
redirect_pc  input  ADDR_WIDTH  redirect target word address
if_valid  output  1  queue head holds a valid instruction
if_instruction  output  DATA_WIDTH  head instruction; 0 when empty
if_pc  output  ADDR_WIDTH  address of the head instruction; 0 when empty
if_ready  input  1  decode accepts the head this cycle
fetch_count  output  32  number of instructions delivered (pops); wraps at 2^32

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC; FIFO read pointer, write pointer and count=0; fetch_count=0; if_valid=0, if_instruction=0, if_pc=0. imem_address follows fetch_pc immediately (RESET_PC).
- Memory timing: imem_instruction is valid in the same cycle as imem_address. It is sampled at the rising edge.
- pop = if_valid && if_ready.
- push = fetch_enable && !redirect_valid && (count < FIFO_DEPTH || pop).
- On push, the FIFO stores {imem_instruction, fetch_pc}, and fetch_pc <= fetch_pc + 1 modulo 2^ADDR_WIDTH, so 1023 wraps to 0.
- Latency: an instruction fetched in cycle T appears on if_valid/if_instruction/if_pc in cycle T+1. There is no combinational bypass from memory to the outputs.
- Full queue: push and pop in the same cycle are both performed, and count stays at FIFO_DEPTH. If full with no pop, there is no push and fetch_pc holds.
- Empty queue: if_valid=0 and outputs are 0. if_ready is ignored.
- Head outputs are driven from the FIFO head entry; if_valid = (count != 0).
- Redirect (redirect_valid=1 at an edge) has priority over push and pop:
  - the FIFO is cleared (count=0);
  - fetch_pc <= redirect_pc;
  - no push occurs, and a handshake in that cycle is not counted (fetch_count unchanged).
  - In cycle T+1, imem_address=redirect_pc and the push occurs. In cycle T+2, if_valid=1 with if_pc=redirect_pc.
  - Back-to-back redirects: the last one wins.
- fetch_enable=0: fetch_pc holds, no push, pop continues normally. A redirect is still honoured.
- fetch_count increments by 1 on every non-redirect pop.
- Reset asserted mid-operation: all state returns to its reset values immediately. After release, fetching restarts at RESET_PC.
- No X on any output after reset. If imem_instruction carries X, the X is passed through as data only.

Test Plan:
1. Reset, memory word[i]=32'h00100000+i, fetch_enable=1, if_ready=1 -> if_valid rises in the cycle after reset release; if_pc sequence 0,1,2,3… with if_instruction 32'h00100000, 32'h00100001…; fetch_count=8 after 8 pops.
2. if_ready=0 for 10 cycles -> count saturates at 4; imem_address holds at 4; if_pc stays 0. Then if_ready=1 -> PCs 0..3 are delivered in order with no gap, followed by PC 4.
3. Full queue with if_ready=1 continuously -> push and pop occur each cycle; if_pc advances by 1 per cycle; there are no bubbles and no lost or duplicated PCs.
4. Redirect to 10'h200 while 3 entries are queued -> next cycle if_valid=0; the following cycle if_pc=10'h200 with if_instruction=word[512]; fetch_count is not incremented in the redirect cycle.
5. Redirect to 10'h3FE -> delivered PCs are 3FE, 3FF, 000, 001.
6. rst_n pulsed low mid-stream with 2 entries queued -> if_valid=0, fetch_count=0 and imem_address=0 asynchronously. After release, delivery restarts at PC 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the fetch PC into a combinational-read instruction
// memory, queues returned words in a prefetch FIFO and hands them to decode via valid/ready.
module instruction_fetch_unit #(
    parameter int unsigned              ADDR_WIDTH = 10,
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0,
    parameter int unsigned              FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_enable,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_instruction,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_instruction,
    output logic [ADDR_WIDTH-1:0] if_pc,
    input  logic                  if_ready,
    output logic [31:0]           fetch_count
);

    localparam int unsigned     PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W:0]        r_count;
    logic [31:0]           r_fetch_count;
    logic [DATA_WIDTH-1:0] r_fifo_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];

    logic w_valid;
    logic w_pop;
    logic w_push;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && if_ready;
    // A full queue still accepts a new word when the head leaves in the same cycle.
    assign w_push  = fetch_enable && !redirect_valid && ((r_count < DEPTH_C) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_fetch_count <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_fetch_pc <= r_fetch_pc + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr      <= r_rd_ptr + 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: the head is only exposed while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_instruction;
            r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
        end
    end

    assign imem_address   = r_fetch_pc;
    assign if_valid       = w_valid;
    assign if_instruction = w_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign if_pc          = w_valid ? r_fifo_pc[r_rd_ptr]    : '0;
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory word[i] = 32'h00100000 + i.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_enable;
    logic [9:0]  imem_address;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [9:0]  if_pc;
    logic        if_ready;
    logic [31:0] fetch_count;

    int n_checks;
    int n_fail;

    instruction_fetch_unit #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .RESET_PC   (10'd0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_enable     (fetch_enable),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_valid         (if_valid),
        .if_instruction   (if_instruction),
        .if_pc            (if_pc),
        .if_ready         (if_ready),
        .fetch_count      (fetch_count)
    );

    assign imem_instruction = 32'h0010_0000 + {22'd0, imem_address};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset(input logic en, input logic rdy);
        rst_n          = 1'b0;
        fetch_enable   = en;
        if_ready       = rdy;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n          = 1'b0;
        fetch_enable   = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
        n_checks++; if (if_instruction !== 32'd0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", if_instruction); end
        n_checks++; if (if_pc !== 10'd0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
        n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        n_checks++; if (imem_address !== 10'd0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", imem_address); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, if_valid); end
            n_checks++; if (if_pc !== 10'(k)) begin n_fail++; $display("FAIL stream_pc got=%h exp=%h", if_pc, 10'(k)); end
            n_checks++; if (if_instruction !== 32'h0010_0000 + 32'(k)) begin n_fail++; $display("FAIL stream_instr got=%h exp=%h", if_instruction, 32'h0010_0000 + 32'(k)); end
            n_checks++; if (fetch_count !== 32'(k)) begin n_fail++; $display("FAIL stream_count got=%0d exp=%0d", fetch_count, k); end
        end
        @(negedge clk);
        n_checks++; if (fetch_count !== 32'd8) begin n_fail++; $display("FAIL stream_count8 got=%0d exp=8", fetch_count); end
    endtask

    task automatic test_backpressure;
        apply_reset(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        n_checks++; if (imem_address !== 10'd4) begin n_fail++; $display("FAIL bp_addr got=%h exp=4", imem_address); end
        n_checks++; if (if_pc !== 10'd0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head got=%h/%b exp=0/1", if_pc, if_valid); end
        n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL bp_count got=%0d exp=0", fetch_count); end
        if_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_checks++; if (if_valid !== 1'b1 || if_pc !== 10'(k)) begin n_fail++; $display("FAIL bp_drain got=%h/%b exp=%h/1", if_pc, if_valid, 10'(k)); end
            n_checks++; if (fetch_count !== 32'(k)) begin n_fail++; $display("FAIL bp_drain_count got=%0d exp=%0d", fetch_count, k); end
        end
    endtask

    task automatic test_back_to_back;
        apply_reset(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        if_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            n_checks++; if (if_valid !== 1'b1 || if_pc !== 10'(k)) begin n_fail++; $display("FAIL b2b_pc got=%h/%b exp=%h/1", if_pc, if_valid, 10'(k)); end
            n_checks++; if (imem_address !== 10'(k + 4)) begin n_fail++; $display("FAIL b2b_addr got=%h exp=%h", imem_address, 10'(k + 4)); end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect;
        apply_reset(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (if_pc !== 10'd0 || imem_address !== 10'd3) begin n_fail++; $display("FAIL redir_pre got=%h/%h exp=0/3", if_pc, imem_address); end
        redirect_valid = 1'b1;
        redirect_pc    = 10'h200;
        if_ready       = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got=%b exp=0", if_valid); end
        n_checks++; if (imem_address !== 10'h200) begin n_fail++; $display("FAIL redir_addr got=%h exp=200", imem_address); end
        n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL redir_count got=%0d exp=0", fetch_count); end
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 10'h200) begin n_fail++; $display("FAIL redir_head got=%h/%b exp=200/1", if_pc, if_valid); end
        n_checks++; if (if_instruction !== 32'h0010_0200) begin n_fail++; $display("FAIL redir_instr got=%h exp=00100200", if_instruction); end
        @(negedge clk);
        n_checks++; if (if_pc !== 10'h201 || fetch_count !== 32'd1) begin n_fail++; $display("FAIL redir_next got=%h/%0d exp=201/1", if_pc, fetch_count); end
    endtask

    task automatic test_redirect_wrap;
        apply_reset(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 10'h100;
        @(negedge clk);
        n_checks++; if (imem_address !== 10'h100 || if_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_first got=%h/%b exp=100/0", imem_address, if_valid); end
        redirect_pc = 10'h3FE;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_checks++; if (imem_address !== 10'h3FE || if_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_last got=%h/%b exp=3fe/0", imem_address, if_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (if_valid !== 1'b1 || if_pc !== 10'(10'h3FE + k)) begin n_fail++; $display("FAIL wrap_pc got=%h exp=%h", if_pc, 10'(10'h3FE + k)); end
            n_checks++; if (if_instruction !== 32'h0010_0000 + {22'd0, 10'(10'h3FE + k)}) begin n_fail++; $display("FAIL wrap_instr got=%h", if_instruction); end
        end
    endtask

    task automatic test_fetch_disable;
        apply_reset(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        fetch_enable = 1'b0;
        if_ready     = 1'b1;
        @(negedge clk);
        n_checks++; if (if_pc !== 10'd1 || imem_address !== 10'd2) begin n_fail++; $display("FAIL dis_drain got=%h/%h exp=1/2", if_pc, imem_address); end
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b0 || fetch_count !== 32'd2) begin n_fail++; $display("FAIL dis_empty got=%b/%0d exp=0/2", if_valid, fetch_count); end
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b0 || imem_address !== 10'd2) begin n_fail++; $display("FAIL dis_hold got=%b/%h exp=0/2", if_valid, imem_address); end
        redirect_valid = 1'b1;
        redirect_pc    = 10'h050;
        @(negedge clk);
        redirect_valid = 1'b0;
        fetch_enable   = 1'b1;
        n_checks++; if (imem_address !== 10'h050) begin n_fail++; $display("FAIL dis_redir got=%h exp=050", imem_address); end
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 10'h050) begin n_fail++; $display("FAIL dis_resume got=%h/%b exp=050/1", if_pc, if_valid); end
    endtask

    task automatic test_reset_midstream;
        apply_reset(1'b1, 1'b1);
        repeat (4) @(negedge clk);
        if_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (fetch_count !== 32'd3 || if_pc !== 10'd3) begin n_fail++; $display("FAIL mid_pre got=%0d/%h exp=3/3", fetch_count, if_pc); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (if_valid !== 1'b0 || fetch_count !== 32'd0) begin n_fail++; $display("FAIL mid_async got=%b/%0d exp=0/0", if_valid, fetch_count); end
        n_checks++; if (imem_address !== 10'd0) begin n_fail++; $display("FAIL mid_addr got=%h exp=0", imem_address); end
        @(negedge clk);
        rst_n    = 1'b1;
        if_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 10'd0) begin n_fail++; $display("FAIL mid_restart got=%h/%b exp=0/1", if_pc, if_valid); end
        @(negedge clk);
        n_checks++; if (if_pc !== 10'd1 || fetch_count !== 32'd1) begin n_fail++; $display("FAIL mid_next got=%h/%0d exp=1/1", if_pc, fetch_count); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset;
        test_stream;
        test_backpressure;
        test_back_to_back;
        test_redirect;
        test_redirect_wrap;
        test_fetch_disable;
        test_reset_midstream;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
